// File: rtl/vc_output_scheduler_pkg.sv
// vc_output_scheduler_pkg
// Shared definitions for the VC output scheduler slice:
//   - VC0 / VC1 identifiers used to index per-VC vectors
//   - default destination-select bit position
//   - owner_t enum describing which VC currently holds the round
//   - cnt_width(): credit counter width derived from the two weights
package vc_output_scheduler_pkg;

    localparam logic VC0 = 1'b0;
    localparam logic VC1 = 1'b1;

    localparam int DEFAULT_DEST_BIT = 4;

    typedef enum logic {
        OWN_VC0 = 1'b0,
        OWN_VC1 = 1'b1
    } owner_t;

    // The counter must be able to hold the largest weight itself, because
    // the "credit used up" test compares the incremented count against W.
    function automatic int cnt_width(input int w0, input int w1);
        int w_max;
        int w_bits;
        w_max  = (w0 > w1) ? w0 : w1;
        w_bits = $clog2(w_max + 1);
        return (w_bits < 1) ? 1 : w_bits;
    endfunction

endpackage

// File: rtl/vc_output_scheduler_if.sv
// vc_output_scheduler_if
// Bundles the FIFO-facing signals of the scheduler.
//   master : scheduler side (reads FIFO status/heads, drives pops/pushes)
//   slave  : FIFO / environment side
// Signals:
//   fifo_empty_vc0/1, data_vc0/1 : VC FIFO status and first-word-fall-through heads
//   fifo_pause_d0/1              : destination almost-full indications
//   pop_vc0/1                    : combinational pops
//   push_d0/1, data_out          : registered pushes and the pushed word
//   last_vc, idle                : registered status
interface vc_output_scheduler_if #(
    parameter int BW = 6
);
    logic          fifo_empty_vc0;
    logic          fifo_empty_vc1;
    logic [BW-1:0] data_vc0;
    logic [BW-1:0] data_vc1;
    logic          fifo_pause_d0;
    logic          fifo_pause_d1;
    logic          pop_vc0;
    logic          pop_vc1;
    logic          push_d0;
    logic          push_d1;
    logic [BW-1:0] data_out;
    logic          last_vc;
    logic          idle;

    modport master (
        input  fifo_empty_vc0, fifo_empty_vc1,
        input  data_vc0, data_vc1,
        input  fifo_pause_d0, fifo_pause_d1,
        output pop_vc0, pop_vc1,
        output push_d0, push_d1,
        output data_out, last_vc, idle
    );

    modport slave (
        output fifo_empty_vc0, fifo_empty_vc1,
        output data_vc0, data_vc1,
        output fifo_pause_d0, fifo_pause_d1,
        input  pop_vc0, pop_vc1,
        input  push_d0, push_d1,
        input  data_out, last_vc, idle
    );

endinterface

// File: rtl/vc_output_scheduler_wrr_ctrl.sv
// vc_wrr_ctrl
// Weighted round-robin grant controller for two virtual channels.
// The owner VC may take up to W_owner consecutive grants; when the owner is
// not eligible the other VC is served immediately and takes over the round
// (the previous owner's remaining credit is lost).
// Ports:
//   clk, reset_L          : clock, synchronous active-low reset
//   elig_vc0, elig_vc1    : VC has a routable head word this cycle
//   grant_vc0, grant_vc1  : one-hot-or-zero grant, combinational
module vc_wrr_ctrl
    import vc_output_scheduler_pkg::*;
#(
    parameter int W0 = 3,
    parameter int W1 = 1
) (
    input  logic clk,
    input  logic reset_L,
    input  logic elig_vc0,
    input  logic elig_vc1,
    output logic grant_vc0,
    output logic grant_vc1
);

    localparam int CW = cnt_width(W0, W1);
    localparam logic [CW-1:0] W0_C  = CW'(W0);
    localparam logic [CW-1:0] W1_C  = CW'(W1);
    localparam logic [CW-1:0] ONE_C = CW'(1);

    owner_t        owner_reg, owner_next;
    logic [CW-1:0] cnt_reg, cnt_next;

    logic          owner_is_vc1;
    logic          own_elig;
    logic          oth_elig;
    logic [CW-1:0] own_w;
    logic [CW-1:0] oth_w;
    logic [CW-1:0] cnt_inc;
    owner_t        owner_flip;

    assign owner_is_vc1 = (owner_reg == OWN_VC1);
    assign own_elig     = owner_is_vc1 ? elig_vc1 : elig_vc0;
    assign oth_elig     = owner_is_vc1 ? elig_vc0 : elig_vc1;
    assign own_w        = owner_is_vc1 ? W1_C : W0_C;
    assign oth_w        = owner_is_vc1 ? W0_C : W1_C;
    assign cnt_inc      = cnt_reg + ONE_C;
    assign owner_flip   = owner_is_vc1 ? OWN_VC0 : OWN_VC1;

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            owner_reg <= OWN_VC0;
            cnt_reg   <= '0;
        end else begin
            owner_reg <= owner_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        grant_vc0  = 1'b0;
        grant_vc1  = 1'b0;
        owner_next = owner_reg;
        cnt_next   = cnt_reg;

        if (own_elig) begin
            grant_vc0 = !owner_is_vc1;
            grant_vc1 = owner_is_vc1;
            if (cnt_inc == own_w) begin
                owner_next = owner_flip;
                cnt_next   = '0;
            end else begin
                cnt_next   = cnt_inc;
            end
        end else if (oth_elig) begin
            grant_vc0 = owner_is_vc1;
            grant_vc1 = !owner_is_vc1;
            // Taking over with a weight of 1 uses the whole round at once,
            // so ownership bounces straight back to the current owner.
            if (oth_w == ONE_C) begin
                owner_next = owner_reg;
                cnt_next   = '0;
            end else begin
                owner_next = owner_flip;
                cnt_next   = ONE_C;
            end
        end
    end

endmodule

// File: rtl/vc_output_scheduler.sv
// vc_output_scheduler
// Moves words from two VC FIFOs into two destination FIFOs. Each cycle at
// most one VC with a routable head (its destination not paused) is popped
// under weighted round-robin; the popped word is pushed one cycle later to
// the destination chosen by bit DEST_BIT of the word.
// Ports:
//   clk      : clock
//   reset_L  : synchronous active-low reset
//   bus      : vc_output_scheduler_if.master (FIFO status, pops, pushes, status)
module vc_output_scheduler
    import vc_output_scheduler_pkg::*;
#(
    parameter int BW       = 6,
    parameter int DEST_BIT = DEFAULT_DEST_BIT,
    parameter int W0       = 3,
    parameter int W1       = 1
) (
    input  logic                   clk,
    input  logic                   reset_L,
    vc_output_scheduler_if.master  bus
);

    logic [1:0]    empty_vec;
    logic [1:0]    pause_vec;
    logic [BW-1:0] head [2];
    logic [1:0]    elig;
    logic [1:0]    grant;

    logic [BW-1:0] granted_word;
    logic          granted_dest;

    logic [BW-1:0] data_out_reg;
    logic          push_d0_reg;
    logic          push_d1_reg;
    logic          last_vc_reg;
    logic          idle_reg;

    assign empty_vec = {bus.fifo_empty_vc1, bus.fifo_empty_vc0};
    assign pause_vec = {bus.fifo_pause_d1, bus.fifo_pause_d0};
    assign head[0]   = bus.data_vc0;
    assign head[1]   = bus.data_vc1;

    // A VC is eligible only if the destination its own head targets is
    // open; a paused destination never blocks a VC heading elsewhere.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_elig
            assign elig[gi] = !empty_vec[gi]
                           && !pause_vec[head[gi][DEST_BIT]]
                           && reset_L;
        end
    endgenerate

    vc_wrr_ctrl #(
        .W0 (W0),
        .W1 (W1)
    ) u_wrr_ctrl (
        .clk       (clk),
        .reset_L   (reset_L),
        .elig_vc0  (elig[VC0]),
        .elig_vc1  (elig[VC1]),
        .grant_vc0 (grant[VC0]),
        .grant_vc1 (grant[VC1])
    );

    assign bus.pop_vc0 = grant[VC0];
    assign bus.pop_vc1 = grant[VC1];

    assign granted_word = grant[VC1] ? head[1] : head[0];
    assign granted_dest = granted_word[DEST_BIT];

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            data_out_reg <= '0;
            push_d0_reg  <= 1'b0;
            push_d1_reg  <= 1'b0;
            last_vc_reg  <= VC0;
            idle_reg     <= 1'b1;
        end else if (|grant) begin
            data_out_reg <= granted_word;
            push_d0_reg  <= !granted_dest;
            push_d1_reg  <= granted_dest;
            last_vc_reg  <= grant[VC1];
            idle_reg     <= 1'b0;
        end else begin
            push_d0_reg  <= 1'b0;
            push_d1_reg  <= 1'b0;
            idle_reg     <= 1'b1;
        end
    end

    // The in-flight word is dropped when reset arrives right behind its pop:
    // the push is masked for the whole reset cycle, not only after the edge.
    assign bus.push_d0  = push_d0_reg && reset_L;
    assign bus.push_d1  = push_d1_reg && reset_L;
    assign bus.data_out = data_out_reg;
    assign bus.last_vc  = last_vc_reg;
    assign bus.idle     = idle_reg;

endmodule

// File: doc/vc_output_scheduler.md
# vc_output_scheduler

Sequential weighted round-robin scheduler that sits between the two virtual-channel FIFOs (vc0, vc1) and the two destination FIFOs (d0, d1). Each cycle it picks at most one VC whose head word is routable, because its destination FIFO is not paused, and pops that VC. One cycle later it pushes the word into the destination selected by the word's destination bit. It replaces the fixed vc0-over-vc1 priority pop with a fair, configurable share and per-destination backpressure.

## Interface
Parameters:
- BW, 6: data word width.
- DEST_BIT, 4: bit of the word that selects the destination (0 = d0, 1 = d1).
- W0, 3: consecutive grants allowed to vc0 per round. Must be at least 1.
- W1, 1: consecutive grants allowed to vc1 per round. Must be at least 1.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- reset_L, input, 1: synchronous, active-low reset.
- fifo_empty_vc0, input, 1: vc0 FIFO empty.
- fifo_empty_vc1, input, 1: vc1 FIFO empty.
- data_vc0, input, BW: vc0 head word (first-word-fall-through, valid while not empty).
- data_vc1, input, BW: vc1 head word.
- fifo_pause_d0, input, 1: d0 almost-full.
- fifo_pause_d1, input, 1: d1 almost-full.
- pop_vc0, output, 1: pop vc0 this cycle (combinational).
- pop_vc1, output, 1: pop vc1 this cycle (combinational).
- push_d0, output, 1: push data_out into d0 (registered).
- push_d1, output, 1: push data_out into d1 (registered).
- data_out, output, BW: word being pushed (registered).
- last_vc, output, 1: VC served by the last grant (registered).
- idle, output, 1: no grant was issued in the previous cycle (registered).

## Operation
Eligibility:
- elig_vcX = !fifo_empty_vcX && !fifo_pause_d[data_vcX[DEST_BIT]] && reset_L.
- A paused destination blocks only VCs whose head word targets it.

State:
- owner: 1 bit, which VC holds the round.
- cnt: credit counter, width $clog2(max(W0,W1)+1).

Grant rule, evaluated every cycle:
- Owner eligible: grant owner and increment cnt. If the new cnt equals W_owner, owner flips and cnt resets to 0.
- Owner not eligible, other VC eligible: grant the other VC. owner becomes that VC with cnt=1; if that VC's W is 1, owner flips straight back and cnt=0. The unused credit of the previous owner is forfeited.
- Neither eligible: no grant; owner and cnt hold.

Outputs:
- pop_vcX = grant to VCX. At most one pop is asserted in any cycle.
- On a grant at edge N+1: data_out gets the granted head word; push_dY=1 for Y = word[DEST_BIT], the other push=0; last_vc gets the granted VC; idle=0.
- Without a grant: push_d0 and push_d1 are 0, data_out and last_vc hold, idle=1.

Reset values (sampled at the edge with reset_L=0):
- owner=vc0, cnt=0.
- push_d0=0, push_d1=0, data_out=0, last_vc=0, idle=1.
- pop_vc0 and pop_vc1 are forced to 0 while reset_L=0.

## Timing
- Pop to push latency is 1 cycle: pop in cycle N produces push and data_out in cycle N+1.
- Throughput is one word per cycle when any VC is eligible.
- Destination FIFOs must assert fifo_pause_dX with at least 1 free entry left, to absorb the single in-flight word.
- Reset mid-operation: a word popped in the cycle before the reset edge is dropped (its push is cleared). Scheduling restarts from owner=vc0.
- Simultaneous pause change and pop: eligibility uses the pause value of the current cycle; there is no lookahead.
- Heads of both VCs targeting the same unpaused destination: the arbitration rule alone decides.

## Structure
- Shared package holds:
  - localparams VC0=1'b0 and VC1=1'b1;
  - the default DEST_BIT;
  - a helper function computing the counter width from W0 and W1.
- Natural sub-module: vc_wrr_ctrl, containing owner, cnt and the grant logic, with elig_vc0/elig_vc1 in and grant_vc0/grant_vc1 out.
- The top level adds the eligibility decode, the output register stage and the destination demux.

## Test plan
- Reset: reset_L=0 for 3 cycles with both VCs non-empty -> pops 0, push_d0 and push_d1 0, data_out=0, idle=1.
- Continuous load, W0=3, W1=1, both VCs non-empty, all words dest d0 -> pop pattern vc0,vc0,vc0,vc1 repeating. push_d0 follows one cycle later with the matching data; push_d1 stays 0.
- Only vc1 non-empty -> pop_vc1 every cycle, last_vc=1, no vc0 pops.
- vc0 head 6'b010101 (dest d1) with fifo_pause_d1=1, vc1 head 6'b000011 (dest d0) -> vc1 popped, next cycle push_d0=1 with data_out=6'b000011; vc0 is not popped until pause_d1 drops.
- Both VCs empty for 4 cycles -> no pops, idle=1. On refill the arbitration resumes with the held owner and cnt.
- Pop vc0 in cycle N with reset_L=0 in cycle N+1 -> no push at N+1; after reset the first grant goes to vc0 when both VCs are eligible.
